// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: pipeline payload types shared by the execute, load/store and
// write-back stages, plus the load/store FSM state encoding.
package cpu_types_pkg;
  localparam int XLEN = 32;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc_target;
    logic [XLEN-1:0] exu_result;
    logic            reg_wen;
    logic [4:0]      rd_addr;
    logic            mem_en;
    logic            mem_wen;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_addr;
    logic [2:0]      funct3;
  } ex_lsu_t;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc_target;
    logic [XLEN-1:0] wb_data;
    logic            reg_wen;
    logic [4:0]      rd_addr;
    logic            err;
  } lsu_wb_t;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} mem_size_e;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_WAIT_WB} lsu_state_e;
endpackage

// File: rtl/stage_if.sv
// stage_if: pipeline stage handshake; the payload carries its own valid bit.
interface stage_if #(parameter type T = logic);
  T     data;
  logic ready;
  modport master (output data, input ready);
  modport slave (input data, output ready);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: store byte-lane/strobe generation, load extract/extend, and
// access legality (misalignment and unsupported funct3) checks.
module lsu_align
  import cpu_types_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic        i_wen,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_illegal
);
  mem_size_e   w_size;
  logic [31:0] w_shift;
  logic        w_sext;
  always_comb begin
    w_size       = i_funct3[1] ? WORD : i_funct3[0] ? HALF : BYTE;
    w_shift      = i_rdata >> {i_addr_lo, 3'b000};
    w_sext       = ~i_funct3[2];
    o_illegal    = i_wen ? (i_funct3[2] | &i_funct3[1:0]) : (&i_funct3[1:0] | &i_funct3[2:1]);
    o_misaligned = (w_size == HALF & i_addr_lo[0]) | (w_size == WORD & |i_addr_lo);
    o_wstrb      = !i_wen ? 4'h0 : w_size == WORD ? 4'hF : w_size == HALF ? 4'b0011 << i_addr_lo : 4'b0001 << i_addr_lo;
    o_wdata      = w_size == WORD ? i_wdata : w_size == HALF ? {2{i_wdata[15:0]}} : {4{i_wdata[7:0]}};
    o_rdata      = w_size == WORD ? i_rdata :
                   w_size == HALF ? {{16{w_sext & w_shift[15]}}, w_shift[15:0]} :
                                    {{24{w_sext & w_shift[7]}}, w_shift[7:0]};
  end
endmodule

// File: rtl/lsu_unit.sv
// lsu_unit: load/store stage; runs at most one data-memory transaction per op
// and hands a write-back payload on, passing non-memory ops through in one cycle.
module lsu_unit
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  stage_if.slave            lsu_in,
  stage_if.master           lsu_out,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_wen,
  output logic [ADDR_W-1:0] dmem_req_addr,
  output logic [DATA_W-1:0] dmem_req_wdata,
  output logic [3:0]        dmem_req_wstrb,
  input  logic              dmem_rsp_valid,
  input  logic [DATA_W-1:0] dmem_rsp_rdata,
  input  logic              dmem_rsp_err,
  output logic              dmem_rsp_ready
);
  lsu_state_e        r_state, w_next;
  ex_lsu_t           w_in;
  lsu_wb_t           r_out;
  logic [2:0]        r_funct3;
  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;
  logic              w_idle, w_take, w_bad, w_misaligned, w_illegal;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_wdata, w_rdata;
  assign w_in   = lsu_in.data;
  assign w_idle = r_state == S_IDLE;
  assign w_take = w_idle & w_in.valid;
  assign w_bad  = w_in.mem_en & (w_misaligned | w_illegal);
  // While idle the aligner decodes the incoming op; afterwards the latched one.
  lsu_align u_align (
    .i_funct3     (w_idle ? w_in.funct3 : r_funct3),
    .i_wen        (w_idle ? w_in.mem_wen : r_wen),
    .i_addr_lo    (w_idle ? w_in.mem_addr[1:0] : r_addr[1:0]),
    .i_wdata      (w_in.mem_wdata),
    .i_rdata      (dmem_rsp_rdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_rdata      (w_rdata),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next         = r_state;
    lsu_in.ready   = w_idle;
    dmem_req_valid = r_state == S_REQ;
    dmem_rsp_ready = r_state == S_RSP;
    case (r_state)
      S_IDLE:  w_next = !w_in.valid ? S_IDLE : (!w_in.mem_en || w_bad) ? S_WAIT_WB : S_REQ;
      S_REQ:   w_next = dmem_req_ready ? S_RSP : S_REQ;
      S_RSP:   w_next = dmem_rsp_valid ? S_WAIT_WB : S_RSP;
      default: w_next = lsu_out.ready ? S_IDLE : S_WAIT_WB;
    endcase
  end
  // Stores and faulted accesses never write a register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_out    <= '0;
      r_funct3 <= '0;
      r_wen    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      if (w_take) begin
        r_out.valid     <= !w_in.mem_en || w_bad;
        r_out.pc_target <= w_in.pc_target;
        r_out.wb_data   <= w_in.exu_result;
        r_out.reg_wen   <= w_in.reg_wen & !(w_in.mem_en & (w_in.mem_wen | w_bad));
        r_out.rd_addr   <= w_in.rd_addr;
        r_out.err       <= w_bad;
        r_funct3        <= w_in.funct3;
        r_wen           <= w_in.mem_wen;
        r_addr          <= w_in.mem_addr[ADDR_W-1:0];
        r_wdata         <= w_wdata;
        r_wstrb         <= w_wstrb;
      end
      if (r_state == S_RSP && dmem_rsp_valid) begin
        r_out.valid   <= 1'b1;
        r_out.wb_data <= w_rdata;
        r_out.reg_wen <= r_out.reg_wen & !dmem_rsp_err;
        r_out.err     <= dmem_rsp_err;
      end
      if (r_state == S_WAIT_WB && lsu_out.ready) r_out.valid <= 1'b0;
    end
  assign lsu_out.data   = r_out;
  assign dmem_req_wen   = r_wen;
  assign dmem_req_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign dmem_req_wdata = r_wdata;
  assign dmem_req_wstrb = r_wstrb;
endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: directed and randomized checks of lsu_unit against a byte-level
// reference model, with a scripted memory responder.
module tb_lsu_unit;
  import cpu_types_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_wen;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_wstrb;
  logic        dmem_rsp_valid, dmem_rsp_err, dmem_rsp_ready;
  logic [31:0] dmem_rsp_rdata;
  int          total = 0;
  int          bad = 0;
  stage_if #(.T(ex_lsu_t)) u_in ();
  stage_if #(.T(lsu_wb_t)) u_out ();
  lsu_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lsu_in         (u_in),
    .lsu_out        (u_out),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_req_wen   (dmem_req_wen),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_req_wstrb (dmem_req_wstrb),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata),
    .dmem_rsp_err   (dmem_rsp_err),
    .dmem_rsp_ready (dmem_rsp_ready)
  );
  always #5 clk = ~clk;
  typedef struct {
    int          t_req;
    int          t_out;
    logic        timeout;
    logic        in_ready_at_fire;
    logic        req_stable;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_wen;
    logic        rsp_ready_ok;
    logic        out_stable;
    logic        in_ready_low_hold;
    logic        in_ready_after;
    lsu_wb_t     out;
  } obs_t;
  typedef struct {
    logic        want_req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wen;
    logic        reg_wen;
    logic        err;
    logic        chk_data;
    logic [31:0] wb_data;
    int          lat;
  } exp_t;
  // Reference: byte-granular view of the access rules.
  function automatic exp_t model(input ex_lsu_t p, input logic [31:0] rd, input logic re, input int req_stall);
    exp_t        m;
    int          n, off;
    logic        legal;
    logic [31:0] v, mask;
    m = '{default: 0};
    if (!p.mem_en) begin
      m.reg_wen  = p.reg_wen;
      m.chk_data = 1;
      m.wb_data  = p.exu_result;
      m.lat      = 1;
      return m;
    end
    n     = (p.funct3[1:0] == 2'd0) ? 1 : (p.funct3[1:0] == 2'd1) ? 2 : 4;
    off   = int'(p.mem_addr % 4);
    legal = p.mem_wen ? (p.funct3 inside {3'd0, 3'd1, 3'd2}) : (p.funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal || (off % n) != 0) begin
      m.err = 1;
      m.lat = 1;
      return m;
    end
    m.want_req = 1;
    m.addr     = p.mem_addr & ~32'h3;
    m.wen      = p.mem_wen;
    m.lat      = 3 + req_stall;
    m.err      = re;
    if (p.mem_wen) begin
      for (int i = 0; i < 4; i++) begin
        m.wstrb[i]        = (i >= off) && (i < off + n);
        m.wdata[8*i +: 8] = p.mem_wdata[8*(i%n) +: 8];
      end
    end else begin
      m.reg_wen = p.reg_wen & !re;
      if (!re) begin
        v    = rd >> (8 * off);
        mask = (n == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 32'h1;
        v    = v & mask;
        if (!p.funct3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        m.wb_data  = v;
        m.chk_data = 1;
      end
    end
    return m;
  endfunction
  // Drives one op through the DUT and records what was observed; callers judge.
  task automatic run_op(input ex_lsu_t p, input logic [31:0] rd, input logic re,
                        input int req_stall, input int out_stall, output obs_t o);
    int   seen, held;
    logic pend_acc, pend_rsp, pend_out, done;
    o = '{default: 0};
    o.t_req = -1;
    o.t_out = -1;
    o.req_stable = 1;
    o.out_stable = 1;
    o.in_ready_low_hold = 1;
    o.rsp_ready_ok = 1;
    seen = 0; held = 0; pend_acc = 0; pend_rsp = 0; pend_out = 0; done = 0;
    @(negedge clk);
    o.in_ready_at_fire = u_in.ready;
    p.valid = 1'b1;
    u_in.data = p;
    @(posedge clk);
    #1 u_in.data.valid = 1'b0;
    for (int t = 1; t <= 60 && !done; t++) begin
      @(negedge clk);
      if (pend_out) begin
        u_out.ready = 1'b0;
        o.in_ready_after = u_in.ready;
        done = 1;
      end else begin
        if (pend_rsp) begin
          dmem_rsp_valid = 1'b0;
          pend_rsp = 0;
        end
        if (pend_acc) begin
          dmem_req_ready = 1'b0;
          pend_acc = 0;
          o.rsp_ready_ok = dmem_rsp_ready;
          dmem_rsp_valid = 1'b1;
          dmem_rsp_rdata = rd;
          dmem_rsp_err = re;
          pend_rsp = 1;
        end else if (dmem_req_valid) begin
          if (seen == 0) begin
            o.t_req = t;
            o.req_addr = dmem_req_addr;
            o.req_wdata = dmem_req_wdata;
            o.req_wstrb = dmem_req_wstrb;
            o.req_wen = dmem_req_wen;
          end else if ({dmem_req_addr, dmem_req_wdata, dmem_req_wstrb, dmem_req_wen} !==
                       {o.req_addr, o.req_wdata, o.req_wstrb, o.req_wen}) o.req_stable = 0;
          seen++;
          if (seen > req_stall) begin
            dmem_req_ready = 1'b1;
            pend_acc = 1;
          end
        end
        if (u_out.data.valid) begin
          if (o.t_out < 0) begin
            o.t_out = t;
            o.out = u_out.data;
          end else if (u_out.data !== o.out) o.out_stable = 0;
          if (u_in.ready !== 1'b0) o.in_ready_low_hold = 0;
          if (held >= out_stall) begin
            u_out.ready = 1'b1;
            pend_out = 1;
          end
          held++;
        end
      end
    end
    if (!done) begin
      o.timeout = 1;
      u_out.ready = 1'b0;
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (u_in.ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", u_in.ready); end
    total++; if (u_out.data.valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", u_out.data.valid); end
    total++; if (dmem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", dmem_req_valid); end
    total++; if (dmem_rsp_ready !== 1'b0) begin bad++; $display("FAIL reset_rsp_ready got=%b exp=0", dmem_rsp_ready); end
  endtask
  task automatic test_alu();
    ex_lsu_t p;
    obs_t    o;
    p = '0;
    p.pc_target = 32'h0000_1000;
    p.exu_result = 32'h1234_5678;
    p.rd_addr = 5'd5;
    p.reg_wen = 1'b1;
    run_op(p, 32'h0, 1'b0, 0, 0, o);
    total++; if (o.t_out != 1) begin bad++; $display("FAIL alu_latency got=%0d exp=1", o.t_out); end
    total++; if (o.t_req != -1) begin bad++; $display("FAIL alu_no_req got=%0d exp=-1", o.t_req); end
    total++; if (o.out.wb_data !== 32'h1234_5678) begin bad++; $display("FAIL alu_wb_data got=%h exp=12345678", o.out.wb_data); end
    total++; if ({o.out.reg_wen, o.out.err, o.out.rd_addr} !== {1'b1, 1'b0, 5'd5}) begin bad++;
      $display("FAIL alu_ctrl got=%b/%b/%0d exp=1/0/5", o.out.reg_wen, o.out.err, o.out.rd_addr); end
    total++; if (o.out.pc_target !== 32'h0000_1000) begin bad++; $display("FAIL alu_pc got=%h exp=00001000", o.out.pc_target); end
    total++; if (o.in_ready_after !== 1'b1) begin bad++; $display("FAIL alu_in_ready_after got=%b exp=1", o.in_ready_after); end
  endtask
  task automatic test_lb_lbu();
    ex_lsu_t p;
    obs_t    o;
    p = '0;
    p.mem_en = 1'b1;
    p.reg_wen = 1'b1;
    p.rd_addr = 5'd9;
    p.mem_addr = 32'h8000_0003;
    p.funct3 = 3'b000;
    run_op(p, 32'h80FF_0000, 1'b0, 0, 0, o);
    total++; if (o.out.wb_data !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_data got=%h exp=ffffff80", o.out.wb_data); end
    total++; if (o.req_addr !== 32'h8000_0000 || o.t_req != 1) begin bad++;
      $display("FAIL lb_req got=%h@%0d exp=80000000@1", o.req_addr, o.t_req); end
    total++; if ({o.req_wen, o.req_wstrb} !== 5'b0_0000) begin bad++; $display("FAIL lb_req_kind got=%b exp=00000", {o.req_wen, o.req_wstrb}); end
    total++; if (o.t_out != 3) begin bad++; $display("FAIL lb_latency got=%0d exp=3", o.t_out); end
    total++; if (o.rsp_ready_ok !== 1'b1) begin bad++; $display("FAIL lb_rsp_ready got=%b exp=1", o.rsp_ready_ok); end
    total++; if ({o.out.reg_wen, o.out.err} !== 2'b10) begin bad++; $display("FAIL lb_ctrl got=%b exp=10", {o.out.reg_wen, o.out.err}); end
    p.funct3 = 3'b100;
    run_op(p, 32'h80FF_0000, 1'b0, 0, 0, o);
    total++; if (o.out.wb_data !== 32'h0000_0080) begin bad++; $display("FAIL lbu_data got=%h exp=00000080", o.out.wb_data); end
  endtask
  task automatic test_sh_stall();
    ex_lsu_t p;
    obs_t    o;
    p = '0;
    p.mem_en = 1'b1;
    p.mem_wen = 1'b1;
    p.reg_wen = 1'b1;
    p.mem_addr = 32'h8000_0002;
    p.mem_wdata = 32'h0000_BEEF;
    p.funct3 = 3'b001;
    run_op(p, 32'h0, 1'b0, 3, 0, o);
    total++; if (o.req_wstrb !== 4'b1100) begin bad++; $display("FAIL sh_wstrb got=%b exp=1100", o.req_wstrb); end
    total++; if (o.req_wdata !== 32'hBEEF_BEEF) begin bad++; $display("FAIL sh_wdata got=%h exp=beefbeef", o.req_wdata); end
    total++; if (o.req_wen !== 1'b1) begin bad++; $display("FAIL sh_wen got=%b exp=1", o.req_wen); end
    total++; if (o.req_stable !== 1'b1) begin bad++; $display("FAIL sh_req_stable got=%b exp=1", o.req_stable); end
    total++; if ({o.out.reg_wen, o.out.err} !== 2'b00) begin bad++; $display("FAIL sh_ctrl got=%b exp=00", {o.out.reg_wen, o.out.err}); end
    total++; if (o.t_out != 6) begin bad++; $display("FAIL sh_latency got=%0d exp=6", o.t_out); end
  endtask
  task automatic test_misaligned();
    ex_lsu_t p;
    obs_t    o;
    p = '0;
    p.mem_en = 1'b1;
    p.reg_wen = 1'b1;
    p.mem_addr = 32'h8000_0001;
    p.funct3 = 3'b010;
    run_op(p, 32'h0, 1'b0, 0, 0, o);
    total++; if (o.t_req != -1) begin bad++; $display("FAIL mis_no_req got=%0d exp=-1", o.t_req); end
    total++; if ({o.out.reg_wen, o.out.err} !== 2'b01) begin bad++; $display("FAIL mis_ctrl got=%b exp=01", {o.out.reg_wen, o.out.err}); end
    total++; if (o.t_out != 1) begin bad++; $display("FAIL mis_latency got=%0d exp=1", o.t_out); end
  endtask
  task automatic test_rsp_err();
    ex_lsu_t p;
    obs_t    o;
    p = '0;
    p.mem_en = 1'b1;
    p.reg_wen = 1'b1;
    p.pc_target = 32'hCAFE_0004;
    p.mem_addr = 32'h0000_0040;
    p.funct3 = 3'b010;
    run_op(p, 32'h1111_2222, 1'b1, 0, 4, o);
    total++; if ({o.out.reg_wen, o.out.err} !== 2'b01) begin bad++; $display("FAIL rsperr_ctrl got=%b exp=01", {o.out.reg_wen, o.out.err}); end
    total++; if (o.out_stable !== 1'b1) begin bad++; $display("FAIL rsperr_hold got=%b exp=1", o.out_stable); end
    total++; if (o.in_ready_low_hold !== 1'b1) begin bad++; $display("FAIL rsperr_in_ready_low got=%b exp=1", o.in_ready_low_hold); end
    total++; if (o.out.pc_target !== 32'hCAFE_0004) begin bad++; $display("FAIL rsperr_pc got=%h exp=cafe0004", o.out.pc_target); end
    total++; if (o.in_ready_after !== 1'b1) begin bad++; $display("FAIL rsperr_in_ready_after got=%b exp=1", o.in_ready_after); end
  endtask
  task automatic test_async_reset();
    ex_lsu_t p;
    obs_t    o;
    logic    got_req;
    p = '0;
    p.valid = 1'b1;
    p.mem_en = 1'b1;
    p.reg_wen = 1'b1;
    p.mem_addr = 32'h0000_0100;
    p.funct3 = 3'b010;
    @(negedge clk);
    u_in.data = p;
    @(posedge clk);
    #1 u_in.data.valid = 1'b0;
    got_req = 0;
    for (int t = 0; t < 5 && !got_req; t++) begin
      @(negedge clk);
      got_req = dmem_req_valid;
    end
    total++; if (got_req !== 1'b1) begin bad++; $display("FAIL arst_req_seen got=%b exp=1", got_req); end
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    total++; if (dmem_rsp_ready !== 1'b1) begin bad++; $display("FAIL arst_in_rsp got=%b exp=1", dmem_rsp_ready); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({dmem_req_valid, u_out.data.valid, dmem_rsp_ready} !== 3'b000) begin bad++;
      $display("FAIL arst_outputs got=%b exp=000", {dmem_req_valid, u_out.data.valid, dmem_rsp_ready}); end
    total++; if (u_in.ready !== 1'b1) begin bad++; $display("FAIL arst_in_ready got=%b exp=1", u_in.ready); end
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    total++; if ({dmem_req_valid, u_out.data.valid, u_in.ready} !== 3'b001) begin bad++;
      $display("FAIL arst_stray_rsp got=%b exp=001", {dmem_req_valid, u_out.data.valid, u_in.ready}); end
    p = '0;
    p.exu_result = 32'h0BAD_F00D;
    p.reg_wen = 1'b1;
    p.rd_addr = 5'd3;
    run_op(p, 32'h0, 1'b0, 0, 0, o);
    total++; if (o.t_out != 1 || o.out.wb_data !== 32'h0BAD_F00D || o.out.reg_wen !== 1'b1) begin bad++;
      $display("FAIL arst_next_alu got=%0d/%h/%b exp=1/0badf00d/1", o.t_out, o.out.wb_data, o.out.reg_wen); end
  endtask
  task automatic test_random();
    ex_lsu_t     p;
    obs_t        o;
    exp_t        m;
    logic [31:0] rd;
    logic        re;
    int          rs, os;
    for (int k = 0; k < 40; k++) begin
      p = '0;
      p.pc_target = $urandom;
      p.exu_result = $urandom;
      p.reg_wen = 1'($urandom_range(0, 1));
      p.rd_addr = 5'($urandom_range(0, 31));
      p.mem_en = ($urandom_range(0, 3) != 0);
      p.mem_wen = 1'($urandom_range(0, 1));
      p.mem_wdata = $urandom;
      p.mem_addr = $urandom;
      if ($urandom_range(0, 1) == 1) p.mem_addr[1:0] = 2'b00;
      p.funct3 = 3'($urandom_range(0, 7));
      rd = $urandom;
      re = ($urandom_range(0, 7) == 0);
      rs = $urandom_range(0, 3);
      os = $urandom_range(0, 3);
      m = model(p, rd, re, rs);
      run_op(p, rd, re, rs, os, o);
      total++; if (o.timeout || o.in_ready_at_fire !== 1'b1 || o.in_ready_after !== 1'b1) begin bad++;
        $display("FAIL rnd%0d_handshake got=%b/%b/%b exp=0/1/1", k, o.timeout, o.in_ready_at_fire, o.in_ready_after); end
      total++; if (o.t_out != m.lat) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", k, o.t_out, m.lat); end
      total++; if ({o.out.reg_wen, o.out.err} !== {m.reg_wen, m.err}) begin bad++;
        $display("FAIL rnd%0d_ctrl got=%b exp=%b", k, {o.out.reg_wen, o.out.err}, {m.reg_wen, m.err}); end
      total++; if (o.out.pc_target !== p.pc_target || o.out.rd_addr !== p.rd_addr) begin bad++;
        $display("FAIL rnd%0d_pass got=%h/%0d exp=%h/%0d", k, o.out.pc_target, o.out.rd_addr, p.pc_target, p.rd_addr); end
      if (m.chk_data) begin
        total++; if (o.out.wb_data !== m.wb_data) begin bad++; $display("FAIL rnd%0d_wb_data got=%h exp=%h", k, o.out.wb_data, m.wb_data); end
      end
      total++; if ((o.t_req == 1) !== m.want_req) begin bad++; $display("FAIL rnd%0d_req_time got=%0d exp_req=%b", k, o.t_req, m.want_req); end
      if (m.want_req) begin
        total++; if ({o.req_addr, o.req_wen, o.req_wstrb} !== {m.addr, m.wen, m.wstrb}) begin bad++;
          $display("FAIL rnd%0d_req got=%h/%b/%b exp=%h/%b/%b", k, o.req_addr, o.req_wen, o.req_wstrb, m.addr, m.wen, m.wstrb); end
        if (m.wen) begin
          total++; if (o.req_wdata !== m.wdata) begin bad++; $display("FAIL rnd%0d_wdata got=%h exp=%h", k, o.req_wdata, m.wdata); end
        end
        total++; if (o.req_stable !== 1'b1 || o.rsp_ready_ok !== 1'b1) begin bad++;
          $display("FAIL rnd%0d_bus got=%b/%b exp=1/1", k, o.req_stable, o.rsp_ready_ok); end
      end
      total++; if (o.out_stable !== 1'b1 || o.in_ready_low_hold !== 1'b1) begin bad++;
        $display("FAIL rnd%0d_hold got=%b/%b exp=1/1", k, o.out_stable, o.in_ready_low_hold); end
    end
  endtask
  initial begin
    rst_n = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
    dmem_rsp_err = 1'b0;
    u_in.data = '0;
    u_out.ready = 1'b0;
    test_reset();
    test_alu();
    test_lb_lbu();
    test_sh_stall();
    test_misaligned();
    test_rsp_err();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
endmodule

// File: doc/lsu_unit.md
# lsu_unit

Load/store stage between the execute stage and write-back. Accepts one `ex_lsu_t` payload at a time over `stage_if`, runs at most one data-memory transaction on a valid/ready request/response bus, aligns and extends load data, builds store byte strobes, and hands a `lsu_wb_t` payload downstream. Non-memory instructions pass through with one cycle of latency.

## Interface
- `ADDR_W`, default 32: data address width.
- `DATA_W`, default 32: data bus width. Only 32 is supported.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `lsu_in`  stage_if.slave  -  `ex_lsu_t` payload (valid, pc_target, exu_result, reg_wen, rd_addr, mem_en, mem_wen, mem_wdata, mem_addr, funct3).
- `lsu_out`  stage_if.master  -  `lsu_wb_t` payload (valid, pc_target, wb_data, reg_wen, rd_addr, err).
- `dmem_req_valid`  out  1  request valid.
- `dmem_req_ready`  in  1  memory accepts the request.
- `dmem_req_wen`  out  1  1 = store.
- `dmem_req_addr`  out  ADDR_W  word-aligned address (addr[1:0] forced to 0).
- `dmem_req_wdata`  out  DATA_W  store data shifted into the byte lanes.
- `dmem_req_wstrb`  out  4  byte strobes (0 for loads).
- `dmem_rsp_valid`  in  1  response valid. Every request gets exactly one response, loads and stores alike.
- `dmem_rsp_rdata`  in  DATA_W  read word.
- `dmem_rsp_err`  in  1  bus error.
- `dmem_rsp_ready`  out  1  high only in S_RSP.

## Operation
- FSM states: S_IDLE, S_REQ, S_RSP, S_WAIT_WB.
  - S_IDLE: `lsu_in.ready` = 1. On fire, latch the payload.
    - If `mem_en` = 0 → S_WAIT_WB.
    - If `mem_en` = 1 and the access is misaligned → S_WAIT_WB with err = 1.
    - Otherwise → S_REQ.
  - S_REQ: `dmem_req_valid` = 1; the request fields come from latched registers and hold stable until `dmem_req_ready` → S_RSP.
  - S_RSP: wait for `dmem_rsp_valid`. Capture rdata and err → S_WAIT_WB.
  - S_WAIT_WB: `lsu_out.valid` = 1, payload from the output register. On `lsu_out.ready` → S_IDLE.
- Misaligned means: halfword with addr[0] = 1, or word with addr[1:0] ≠ 0. A misaligned access issues no bus request and forces reg_wen = 0.
- funct3 decoding:
  - 000 LB / SB; 001 LH / SH; 010 LW / SW; 100 LBU; 101 LHU.
  - Any other funct3 with `mem_en` = 1 sets err = 1 and issues no request.
- Store lanes:
  - SB: wstrb = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111.
- Load extraction: shift the read word right by 8·addr[1:0], then sign-extend (LB, LH) or zero-extend (LBU, LHU) to 32 bits.
- wb_data per instruction type:
  - load: the extracted value.
  - store: don't-care, with reg_wen forced to 0.
  - non-memory: exu_result.
- A response with `dmem_rsp_err` = 1 sets err = 1 and forces reg_wen = 0.
- `pc_target` passes through unchanged in all cases.

## Timing
- Reset values: state S_IDLE, `lsu_out.valid` 0, `lsu_in.ready` 1 (combinational from state), `dmem_req_valid` 0, `dmem_rsp_ready` 0, output payload valid 0.
- Non-memory instruction: fire at T0, `lsu_out.valid` at T1.
- Memory access: fire at T0, request at T1. The minimum load/store latency is fire to `lsu_out.valid` = 3 cycles (ready at T1, response at T2).
- Request handshake: `dmem_req_valid` never drops before `dmem_req_ready`. Request fields do not change while valid is high.
- A response arriving in the same cycle as the request acceptance is not legal. The memory responds no earlier than the cycle after acceptance.
- `dmem_rsp_valid` outside S_RSP is ignored.
- Back-to-back: `lsu_in.ready` returns high the cycle after the `lsu_out` fire. There is no overlap.
- Asynchronous reset mid-transaction: everything returns to reset values immediately, and the outstanding response is dropped. The bus owner must also be reset.

## Structure
- Add `lsu_wb_t` and a `mem_size_e` enum (BYTE, HALF, WORD) to `cpu_types_pkg`, next to `ex_lsu_t`.
- Sub-module `lsu_align`: combinational store-lane/strobe generation, load extract/extend and the misalignment check. It is unit-testable alone.
- FSM, payload registers and bus control live in `lsu_unit`.

## Test plan
- ALU pass-through: mem_en = 0, exu_result = 0x1234_5678, rd = 5 → lsu_out valid one cycle after fire, with wb_data 0x1234_5678, reg_wen 1, no dmem request.
- LB at addr 0x8000_0003, rdata 0x80FF_0000 → wb_data 0xFFFF_FF80. The same access as LBU → 0x0000_0080. The request address is 0x8000_0000.
- SH at addr 0x8000_0002 with wdata 0x0000_BEEF → wstrb 1100, wdata 0xBEEF_BEEF, reg_wen 0. Holding req_ready low for 3 cycles keeps all request fields stable.
- LW at addr 0x8000_0001 → no dmem request, err 1, reg_wen 0, lsu_out valid at T1.
- LW with `dmem_rsp_err` = 1 → err 1, reg_wen 0. Holding lsu_out.ready low for 4 cycles holds the payload and keeps `lsu_in.ready` low.
- Assert rst_n low while in S_RSP → `dmem_req_valid` and `lsu_out.valid` are 0 immediately. After release, a stray rsp_valid is ignored and the next ALU op completes normally.
